uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200 baud); legal range 8..65535.
REQ-002 SHALL have port clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning reset; synchronous, active-low.
REQ-004 SHALL have port rx_serial, input, 1, meaning the asynchronous serial line; idles high.
REQ-005 SHALL have port rx_ready, output, 1, meaning a one-cycle pulse that rx_byte holds a new valid byte.
REQ-006 SHALL have port rx_byte, output, 8, meaning the last received byte; held until the next valid byte.
REQ-007 SHALL have port frame_err, output, 1, meaning a one-cycle pulse that a stop bit was sampled low.
REQ-008 SHALL have port parity_err, output, 1, meaning a one-cycle pulse that a parity mismatch occurred.

Function
REQ-009 SHALL pass rx_serial through a 2-flop synchronizer; all FSM decisions use the synchronized value (rx_s).
REQ-010 SHALL implement states IDLE, START, DATA, PARITY, STOP, RECOVER.
REQ-011 IDLE: clear bit counter and bit-timer; go to START on rx_s == 0.
REQ-012 START: count to (CLKS_PER_BIT-1)/2 (integer division); at that count, if rx_s == 0 reset timer and go to DATA, else return to IDLE (glitch rejection, no outputs).
REQ-013 DATA: sample rx_s each time the timer reaches CLKS_PER_BIT-1, shifting LSB first into an internal 8-bit shift register; after the 8th sample go to PARITY (macro on) or STOP (macro off).
REQ-014 The bit timer SHALL be a 16-bit counter cleared on every sample; a 3-bit bit index SHALL wrap 7->0 with no overflow side effects.
REQ-015 STOP: sample at CLKS_PER_BIT-1; if rx_s == 1, load rx_byte from the shift register and pulse rx_ready the next cycle, then go to IDLE.
REQ-016 STOP with rx_s == 0: pulse frame_err, leave rx_byte unchanged, do not pulse rx_ready, and go to RECOVER.
REQ-017 RECOVER: stay until rx_s == 1 (break or stuck-low line), then go to IDLE.
REQ-018 rx_ready, frame_err and parity_err SHALL each be high for exactly one clk per frame and never high together.
REQ-019 A new start bit detected in IDLE in the cycle immediately after rx_ready SHALL be received correctly (back-to-back frames, one stop bit).
REQ-020 Any state not listed SHALL transition to IDLE.

Reset
REQ-021 On reset == 0 at a clk edge: state = IDLE, rx_byte = 8'h00, rx_ready = 0, frame_err = 0, parity_err = 0, timer and index = 0, synchronizer flops = 1.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, the remainder of the aborted frame SHALL be treated as line activity (falling edge restarts START).

Configuration
REQ-023 Macro UART_RX_PARITY_EN SHALL compile in the PARITY state: one even-parity bit after data, sampled at CLKS_PER_BIT-1; on mismatch pulse parity_err at the stop-bit decision, suppress rx_ready, and hold rx_byte.
REQ-024 Without UART_RX_PARITY_EN, PARITY SHALL be unreachable, frames SHALL be 8N1, and parity_err SHALL be tied to 0.

Structure
REQ-025 Package uart_pkg SHALL hold the state enum type (4-bit encoding) and the default CLKS_PER_BIT constant.
REQ-026 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, reset value 1).

Verification
REQ-027 CLKS_PER_BIT=16, send 8N1 byte 8'hA5 -> one rx_ready pulse, rx_byte = 8'hA5, no error pulses.
REQ-028 Send 8'h00 then 8'hFF back-to-back with no idle gap -> two rx_ready pulses, rx_byte 8'h00 then 8'hFF.
REQ-029 Low glitch of 4 clk on idle line (CLKS_PER_BIT=16) -> no pulses, FSM back in IDLE.
REQ-030 Send 8'h3C with stop bit forced 0, line held low 40 clk -> frame_err pulse once, rx_byte unchanged, next 8'h5A received after line returns high.
REQ-031 Reset low for 1 clk during DATA of 8'h81 -> outputs cleared, no rx_ready; following 8'h42 received correctly.
REQ-032 With UART_RX_PARITY_EN, send 8'h07 with parity bit 0 -> parity_err pulse, no rx_ready; with parity bit 1 -> rx_ready, rx_byte = 8'h07.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and constants for the UART receiver.
//   uart_state_e         : receiver FSM state encoding (4 bits)
//   CLKS_PER_BIT_DEFAULT : clk cycles per serial bit (50 MHz / 115200 baud)
//   even_parity()        : parity bit that makes the total count of ones even
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        START   = 4'd1,
        DATA    = 4'd2,
        PARITY  = 4'd3,
        STOP    = 4'd4,
        RECOVER = 4'd5
    } uart_state_e;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff -- two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk   : system clock (rising edge)
//   reset : synchronous, active-low; both flops reset to 1 (idle line level)
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- UART receiver, 8 data bits, LSB first, one stop bit.
// Build option: define UART_RX_PARITY_EN to receive one even-parity bit
// between the data bits and the stop bit (8E1); otherwise frames are 8N1
// and parity_err is constant 0.
// Ports:
//   clk        : system clock, all logic on rising edge
//   reset      : synchronous, active-low
//   rx_serial  : asynchronous serial line, idles high
//   rx_ready   : one-cycle pulse, rx_byte holds a newly received byte
//   rx_byte    : last good byte, held until the next good byte
//   frame_err  : one-cycle pulse, stop bit sampled low
//   parity_err : one-cycle pulse, parity mismatch (parity build only)
//   state_dbg  : current FSM state, for observation only
// Output protocol: there is no back-pressure. Each frame ends in at most one
// of rx_ready / frame_err / parity_err, high for exactly one clk; a consumer
// must capture rx_byte in the cycle rx_ready is high or later, before the
// next rx_ready.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_serial,
    output logic        rx_ready,
    output logic [7:0]  rx_byte,
    output logic        frame_err,
    output logic        parity_err,
    output uart_state_e state_dbg
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT - 1) / 2);

    uart_state_e state, state_n;
    logic        rx_s;
    logic [15:0] timer;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;

    // Control strobes from the next-state logic.
    logic timer_clr, timer_inc, idx_clr, shift_en;
    logic ready_set, ferr_set;
    logic parity_ok;
    logic at_half, at_last;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_serial),
        .q     (rx_s)
    );

    assign at_half   = (timer == HALF_LAST);
    assign at_last   = (timer == BIT_LAST);
    assign state_dbg = state;

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic par_capture;
    logic perr_set;
    logic parity_err_r;

    assign parity_ok  = (par_bit == even_parity(shift_reg));
    assign parity_err = parity_err_r;
`else
    assign parity_ok  = 1'b1;
    assign parity_err = 1'b0;
`endif

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ---------------------------------------------------------------
    // Next-state and control decode
    // ---------------------------------------------------------------
    always_comb begin
        state_n   = state;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        idx_clr   = 1'b0;
        shift_en  = 1'b0;
        ready_set = 1'b0;
        ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_capture = 1'b0;
        perr_set    = 1'b0;
`endif

        case (state)
            IDLE: begin
                timer_clr = 1'b1;
                idx_clr   = 1'b1;
                if (!rx_s) begin
                    state_n = START;
                end
            end

            START: begin
                // Re-check the line at mid start bit; a high level here
                // means the falling edge was a glitch.
                if (at_half) begin
                    timer_clr = 1'b1;
                    state_n   = rx_s ? IDLE : DATA;
                end else begin
                    timer_inc = 1'b1;
                end
            end

            DATA: begin
                if (at_last) begin
                    timer_clr = 1'b1;
                    shift_en  = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    timer_inc = 1'b1;
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_last) begin
                    timer_clr   = 1'b1;
                    par_capture = 1'b1;
                    state_n     = STOP;
                end else begin
                    timer_inc = 1'b1;
                end
            end
`endif

            STOP: begin
                if (at_last) begin
                    timer_clr = 1'b1;
                    if (rx_s) begin
                        // Framing is good; parity decides between
                        // delivering the byte and flagging it.
                        if (parity_ok) begin
                            ready_set = 1'b1;
                        end else begin
`ifdef UART_RX_PARITY_EN
                            perr_set = 1'b1;
`endif
                        end
                        state_n = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_n  = RECOVER;
                    end
                end else begin
                    timer_inc = 1'b1;
                end
            end

            RECOVER: begin
                // Wait out a break or stuck-low line before hunting for
                // the next start bit.
                timer_clr = 1'b1;
                if (rx_s) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath: bit timer, bit index, shift register, outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            timer     <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            rx_byte   <= 8'h00;
            rx_ready  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (timer_clr) begin
                timer <= 16'd0;
            end else if (timer_inc) begin
                timer <= timer + 16'd1;
            end

            // bit_idx wraps 7 -> 0 on the last data sample.
            if (idx_clr) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end

            // LSB arrives first, so shift in from the top.
            if (shift_en) begin
                shift_reg <= {rx_s, shift_reg[7:1]};
            end

            if (ready_set) begin
                rx_byte <= shift_reg;
            end

            rx_ready  <= ready_set;
            frame_err <= ferr_set;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            par_bit      <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            if (par_capture) begin
                par_bit <= rx_s;
            end
            parity_err_r <= perr_set;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed self-checking bench for uart_rx at CLKS_PER_BIT=16.
// Honours UART_RX_PARITY_EN: when defined, frames carry a parity bit and
// the parity-error scenarios are exercised.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic        clk;
    logic        reset;
    logic        rx_serial;
    logic        rx_ready;
    logic [7:0]  rx_byte;
    logic        frame_err;
    logic        parity_err;
    uart_state_e state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    // Monitor tallies
    int n_ready   = 0;
    int n_ferr    = 0;
    int n_perr    = 0;
    int n_overlap = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_serial  (rx_serial),
        .rx_ready   (rx_ready),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- monitor (samples on falling edge) ----------------
    always @(negedge clk) begin
        if (rx_ready) begin
            n_ready++;
            got_q.push_back(rx_byte);
        end
        if (frame_err)  n_ferr++;
        if (parity_err) n_perr++;
        if ((32'(rx_ready) + 32'(frame_err) + 32'(parity_err)) > 1) n_overlap++;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_serial = b;
        tick(CPB);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] data, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(par);
        send_bit(stop);
    endtask
`endif

    task automatic send_frame(input logic [7:0] data, input logic stop);
`ifdef UART_RX_PARITY_EN
        send_frame_par(data, ^data, stop);
`else
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop);
`endif
    endtask

    // Compare every byte delivered since queue index 'from' against exp_q.
    task automatic score(input string tag, input int from);
        check({tag, "_count"}, got_q.size() - from, exp_q.size());
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            logic [7:0] g;
            e = exp_q.pop_front();
            g = (got_q.size() > from) ? got_q[from] : 8'hxx;
            from++;
            check({tag, "_byte"}, g, e);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int b_ready, b_ferr, b_perr, q0;

        reset     = 1'b0;
        rx_serial = 1'b1;
        tick(5);

        // Reset state
        check("rst_byte",  rx_byte,    8'h00);
        check("rst_ready", rx_ready,   1'b0);
        check("rst_ferr",  frame_err,  1'b0);
        check("rst_perr",  parity_err, 1'b0);
        check("rst_state", state_dbg,  IDLE);

        reset = 1'b1;
        tick(20);

        // Single byte 0xA5
        b_ferr = n_ferr; b_perr = n_perr; q0 = got_q.size();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        tick(2 * CPB);
        score("a5", q0);
        check("a5_hold", rx_byte, 8'hA5);
        check("a5_ferr", n_ferr - b_ferr, 0);
        check("a5_perr", n_perr - b_perr, 0);

        // Back-to-back 0x00 then 0xFF, no idle gap
        q0 = got_q.size();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(2 * CPB);
        score("b2b", q0);

        // 4-clk low glitch on an idle line
        b_ready = n_ready; b_ferr = n_ferr; b_perr = n_perr;
        rx_serial = 1'b0;
        tick(4);
        rx_serial = 1'b1;
        tick(40);
        check("glitch_ready", n_ready - b_ready, 0);
        check("glitch_ferr",  n_ferr - b_ferr,   0);
        check("glitch_perr",  n_perr - b_perr,   0);
        check("glitch_state", state_dbg, IDLE);

        // 0x3C with stop bit low, line held low 40 clk
        b_ready = n_ready; b_ferr = n_ferr;
        send_frame(8'h3C, 1'b0);
        tick(40);
        check("ferr_pulse", n_ferr - b_ferr,   1);
        check("ferr_ready", n_ready - b_ready, 0);
        check("ferr_hold",  rx_byte, 8'hFF);
        check("ferr_state", state_dbg, RECOVER);
        rx_serial = 1'b1;
        tick(2 * CPB);
        check("recov_state", state_dbg, IDLE);
        q0 = got_q.size();
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        tick(2 * CPB);
        score("after_ferr", q0);

        // Reset pulse in the middle of data bit 7 of 0x81; the sender then
        // leaves the line idle.
        b_ready = n_ready; b_ferr = n_ferr; b_perr = n_perr;
        send_bit(1'b0);
        for (int i = 0; i < 7; i++) send_bit(((8'h81 >> i) & 8'h01) != 0);
        rx_serial = 1'b1;
        tick(CPB / 2);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check("mrst_byte",  rx_byte,   8'h00);
        check("mrst_state", state_dbg, IDLE);
        tick(4 * CPB);
        check("mrst_ready", n_ready - b_ready, 0);
        check("mrst_ferr",  n_ferr - b_ferr,   0);
        check("mrst_perr",  n_perr - b_perr,   0);
        q0 = got_q.size();
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        tick(2 * CPB);
        score("after_rst", q0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit must be 1
        b_ready = n_ready; b_perr = n_perr;
        send_frame_par(8'h07, 1'b0, 1'b1);
        tick(2 * CPB);
        check("par_bad_perr",  n_perr - b_perr,   1);
        check("par_bad_ready", n_ready - b_ready, 0);
        check("par_bad_hold",  rx_byte, 8'h42);
        q0 = got_q.size();
        b_perr = n_perr;
        exp_q.push_back(8'h07);
        send_frame_par(8'h07, 1'b1, 1'b1);
        tick(2 * CPB);
        score("par_good", q0);
        check("par_good_perr", n_perr - b_perr, 0);
`endif

        check("no_overlap", n_overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
